ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Reset rst is synchronous and active-high; all state is sampled on the rising edge of clk.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 valid_i  input  1  decoded instruction present on the *_i operand bus.
REQ-005 aluop_i  input  8  operation code (shared package): NOP, OR, AND, XOR, ADD, SUB, SLL, MUL.
REQ-006 alusel_i  input  3  result class (shared package): RES_NOP, RES_LOGIC.
REQ-007 reg1_i  input  32  source operand 1 (register value or immediate; shift amount in [4:0] for SLL).
REQ-008 reg2_i  input  32  source operand 2 (register value or immediate; shifted value for SLL).
REQ-009 wd_i  input  5  destination register address.
REQ-010 wreg_i  input  1  destination write request.
REQ-011 flush_i  input  1  discard the in-flight instruction.
REQ-012 stallreq_o  output  1  request pipeline hold; high while a multi-cycle operation is in progress.
REQ-013 valid_o  output  1  one-cycle result strobe toward the memory stage.
REQ-014 wd_o  output  5  registered destination address.
REQ-015 wreg_o  output  1  registered write enable.
REQ-016 wdata_o  output  32  registered result.

Function
REQ-017 FSM states are IDLE and MUL_BUSY; reset enters IDLE.
REQ-018 IDLE with valid_i=1 and flush_i=0 accepts the instruction on that edge.
REQ-019 Single-cycle operations register their outputs on the accepting edge: valid_o=1, wd_o=wd_i, wdata_o=result; latency is 1 cycle.
REQ-020 Single-cycle results:
- OR = reg1|reg2
- AND = reg1&reg2
- XOR = reg1^reg2
- ADD = reg1+reg2, mod 2^32, no overflow trap
- SUB = reg1-reg2, mod 2^32
- SLL = reg2<<reg1[4:0]
REQ-021 MUL on accept: latch the operands, clear the accumulator and iteration counter, enter MUL_BUSY, and keep valid_o=0.
REQ-022 MUL_BUSY performs one shift-add iteration per edge for 32 edges; counter runs 0..31.
REQ-023 The MUL result is the low 32 bits of the product, registered on the 32nd iteration edge; then valid_o=1 and the FSM returns to IDLE.
REQ-024 MUL total latency is 32 edges from the accepting edge.
REQ-025 stallreq_o is combinationally 1 exactly while the state is MUL_BUSY.
REQ-026 valid_i is ignored while in MUL_BUSY; upstream holds the next instruction under stall.
REQ-027 valid_o is high for exactly one cycle per completed instruction; otherwise it is 0.
REQ-028 wreg_o = wreg_i & (wd_i != 0) & (aluop is legal), captured on the accepting edge.
REQ-029 Illegal aluop or RES_NOP alusel with valid_i=1 still produces valid_o=1, with wreg_o=0 and wdata_o=0.
REQ-030 flush_i=1 in IDLE: no accept; valid_o=0 on the next cycle.
REQ-031 flush_i=1 in MUL_BUSY: abort, return to IDLE on that edge, and never assert valid_o for the aborted MUL.
REQ-032 flush_i and valid_i both high in the same cycle: flush wins and the instruction is dropped.
REQ-033 When no completion occurs, wd_o, wreg_o and wdata_o clear to 0 on each edge.

Reset
REQ-034 rst=1 forces state=IDLE, counter=0, accumulator=0, valid_o=0, wreg_o=0, wd_o=0, wdata_o=0, stallreq_o=0 on the next edge.
REQ-035 rst mid-MUL aborts the operation, and no result strobe follows.
REQ-036 rst takes priority over flush_i and valid_i.

Structure
REQ-037 aluop/alusel codes, RegBus/RegAddrBus widths, and WriteEnable/WriteDisable constants reside in the shared defines package used by the decode stage.
REQ-038 The iterative multiplier is one sub-module, ex_mul, with the interface start, flush, operands, done and product.
REQ-039 FSM state encoding is local to ex_stage.

Verification
REQ-040 Apply ADD with reg1=0xFFFFFFFF, reg2=2, wd=5, wreg=1 -> one cycle later: valid_o=1, wdata_o=0x00000001, wd_o=5, wreg_o=1.
REQ-041 Apply SLL with reg1=4, reg2=0x0000000F -> wdata_o=0x000000F0; SUB 3-5 -> 0xFFFFFFFE.
REQ-042 Apply MUL with reg1=0x00010001, reg2=0x00010003 -> stallreq_o high for 32 cycles; valid_o pulses once with wdata_o=0x00040003.
REQ-043 Assert flush_i at iteration 10 of a MUL -> stallreq_o drops the next cycle, with no valid_o; the next ADD completes normally.
REQ-044 Apply ORI-style OR with wd=0, wreg=1 -> wreg_o=0; illegal aluop 0xEE -> valid_o=1, wreg_o=0, wdata_o=0.
REQ-045 Assert rst during MUL iteration 20 -> all outputs are 0 the next cycle and state is IDLE; no late strobe occurs.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared defines for decode/execute: bus widths, write-enable levels,
// ALU operation and result-class codes.
package ex_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_SLL = 8'h7c;
    localparam logic [7:0] OP_MUL = 8'h18;

    localparam logic [2:0] RES_NOP   = 3'b000;
    localparam logic [2:0] RES_LOGIC = 3'b001;

    // NOP carries no result, so it never requests a register write.
    function automatic logic op_legal(input logic [7:0] op);
        logic ok;
        ok = 1'b0;
        unique case (op)
            OP_OR, OP_AND, OP_XOR,
            OP_ADD, OP_SUB, OP_SLL,
            OP_MUL: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [RegBus-1:0] alu_result(
        input logic [7:0]        op,
        input logic [RegBus-1:0] a,
        input logic [RegBus-1:0] b
    );
        logic [RegBus-1:0] r;
        r = '0;
        unique case (op)
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = b << a[4:0];
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_mul.sv
// Iterative shift-add multiplier: one partial product per edge,
// 32 iterations, low 32 bits of the product.
module ex_mul
    import ex_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [RegBus-1:0] op1_i,
    input  logic [RegBus-1:0] op2_i,
    output logic              done_o,
    output logic [RegBus-1:0] product_o
);

    logic [RegBus-1:0] mcand_q, mcand_d;
    logic [RegBus-1:0] mplier_q, mplier_d;
    logic [RegBus-1:0] acc_q, acc_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              run_q, run_d;
    logic [RegBus-1:0] acc_next;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (flush_i) begin
            run_d = 1'b0;
            cnt_d = '0;
            acc_d = '0;
        end else if (start_i) begin
            mcand_d  = op1_i;
            mplier_d = op2_i;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                run_d = 1'b0;
            end
        end
    end

    // The final partial sum is presented combinationally on the last edge.
    assign done_o    = run_q && !flush_i && (cnt_q == 5'd31);
    assign product_o = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/arith/shift ops and a 32-cycle
// iterative MUL that stalls the pipeline while busy.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [7:0]            aluop_i,
    input  logic [2:0]            alusel_i,
    input  logic [RegBus-1:0]     reg1_i,
    input  logic [RegBus-1:0]     reg2_i,
    input  logic [RegAddrBus-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic                  stallreq_o,
    output logic                  valid_o,
    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [RegBus-1:0]     wdata_o
);

    typedef enum logic {
        S_IDLE,
        S_MUL_BUSY
    } state_e;

    state_e                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [RegAddrBus-1:0] wd_q, wd_d;
    logic                  wreg_q, wreg_d;
    logic [RegBus-1:0]     wdata_q, wdata_d;
    logic [RegAddrBus-1:0] mwd_q, mwd_d;
    logic                  mwreg_q, mwreg_d;

    logic                  legal;
    logic                  is_mul;
    logic                  accept;
    logic                  mul_start;
    logic                  mul_done;
    logic [RegBus-1:0]     mul_product;

    assign legal  = op_legal(aluop_i) && (alusel_i == RES_LOGIC);
    assign is_mul = legal && (aluop_i == OP_MUL);
    assign accept = (state_q == S_IDLE) && valid_i && !flush_i;

    ex_mul u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .flush_i   (flush_i),
        .op1_i     (reg1_i),
        .op2_i     (reg2_i),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        valid_d   = 1'b0;
        wd_d      = '0;
        wreg_d    = WriteDisable;
        wdata_d   = '0;
        mwd_d     = mwd_q;
        mwreg_d   = mwreg_q;
        mul_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept && is_mul) begin
                    state_d   = S_MUL_BUSY;
                    mul_start = 1'b1;
                    mwd_d     = wd_i;
                    mwreg_d   = wreg_i && (wd_i != '0);
                end else if (accept) begin
                    valid_d = 1'b1;
                    wd_d    = wd_i;
                    wreg_d  = legal && wreg_i && (wd_i != '0);
                    wdata_d = legal ? alu_result(aluop_i, reg1_i, reg2_i) : '0;
                end
            end
            S_MUL_BUSY: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (mul_done) begin
                    state_d = S_IDLE;
                    valid_d = 1'b1;
                    wd_d    = mwd_q;
                    wreg_d  = mwreg_q;
                    wdata_d = mul_product;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            wd_q    <= '0;
            wreg_q  <= WriteDisable;
            wdata_q <= '0;
            mwd_q   <= '0;
            mwreg_q <= WriteDisable;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            mwd_q   <= mwd_d;
            mwreg_q <= mwreg_d;
        end
    end

    assign stallreq_o = (state_q == S_MUL_BUSY);
    assign valid_o    = valid_q;
    assign wd_o       = wd_q;
    assign wreg_o     = wreg_q;
    assign wdata_o    = wdata_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized bench for ex_stage against an arithmetic
// reference model of the execute-stage results and timing.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        flush_i;
    logic        stallreq_o;
    logic        valid_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .flush_i    (flush_i),
        .stallreq_o (stallreq_o),
        .valid_o    (valid_o),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_legal(input logic [7:0] op);
        return op inside {OP_OR, OP_AND, OP_XOR, OP_ADD,
                          OP_SUB, OP_SLL, OP_MUL};
    endfunction

    function automatic logic [31:0] m_res(input logic [7:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return b << a[4:0];
            OP_MUL:  return p[31:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wd, input logic wr,
                          input string tag);
        logic        ok;
        logic [31:0] ed;
        logic        ew;
        ok = m_legal(op) && (sel == RES_LOGIC);
        ed = ok ? m_res(op, a, b) : 32'd0;
        ew = ok && wr && (wd != 5'd0);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = wd;
        wreg_i   = wr;
        valid_i  = 1'b1;
        tick();
        if (ok && op == OP_MUL) begin
            // Upstream keeps a different instruction presented under stall.
            aluop_i = OP_ADD;
            reg1_i  = $urandom;
            reg2_i  = $urandom;
            wd_i    = 5'd7;
            for (int k = 0; k < 32; k++) begin
                chk({tag, ".stall"}, {31'd0, stallreq_o}, 32'd1);
                chk({tag, ".busyvalid"}, {31'd0, valid_o}, 32'd0);
                tick();
            end
        end
        valid_i = 1'b0;
        chk({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
        chk({tag, ".wd"}, {27'd0, wd_o}, {27'd0, wd});
        chk({tag, ".wreg"}, {31'd0, wreg_o}, {31'd0, ew});
        chk({tag, ".wdata"}, wdata_o, ed);
        chk({tag, ".stall0"}, {31'd0, stallreq_o}, 32'd0);
        tick();
        chk({tag, ".pulse"}, {31'd0, valid_o}, 32'd0);
        chk({tag, ".clr"}, wdata_o, 32'd0);
    endtask

    task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
        aluop_i  = OP_MUL;
        alusel_i = RES_LOGIC;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = 5'd9;
        wreg_i   = 1'b1;
        valid_i  = 1'b1;
        tick();
        valid_i  = 1'b0;
    endtask

    logic [7:0] ops [9];

    initial begin
        ops = '{OP_OR, OP_AND, OP_XOR, OP_ADD, OP_SUB,
                OP_SLL, OP_MUL, 8'hee, OP_NOP};
        rst      = 1'b1;
        valid_i  = 1'b0;
        aluop_i  = '0;
        alusel_i = '0;
        reg1_i   = '0;
        reg2_i   = '0;
        wd_i     = '0;
        wreg_i   = 1'b0;
        flush_i  = 1'b0;
        tick();
        tick();
        chk("rst.valid", {31'd0, valid_o}, 32'd0);
        chk("rst.wd", {27'd0, wd_o}, 32'd0);
        chk("rst.wreg", {31'd0, wreg_o}, 32'd0);
        chk("rst.wdata", wdata_o, 32'd0);
        chk("rst.stall", {31'd0, stallreq_o}, 32'd0);
        rst = 1'b0;
        tick();

        run_op(OP_ADD, RES_LOGIC, 32'hffffffff, 32'd2, 5'd5, 1'b1, "add_wrap");
        run_op(OP_SLL, RES_LOGIC, 32'd4, 32'h0000000f, 5'd3, 1'b1, "sll");
        run_op(OP_SUB, RES_LOGIC, 32'd3, 32'd5, 5'd4, 1'b1, "sub");
        run_op(OP_MUL, RES_LOGIC, 32'h00010001, 32'h00010003, 5'd6, 1'b1, "mul");
        run_op(OP_OR, RES_LOGIC, 32'h0000ff00, 32'h12, 5'd0, 1'b1, "or_wd0");
        run_op(8'hee, RES_LOGIC, 32'h1234, 32'h5678, 5'd8, 1'b1, "illegal");
        run_op(OP_ADD, RES_NOP, 32'h1, 32'h2, 5'd8, 1'b1, "resnop");

        // Flush at MUL iteration 10 (counter value 10, the 11th busy edge).
        start_mul(32'h1234, 32'h5678);
        for (int k = 0; k < 10; k++) begin
            chk("fl.stall", {31'd0, stallreq_o}, 32'd1);
            tick();
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl.stall0", {31'd0, stallreq_o}, 32'd0);
        chk("fl.valid0", {31'd0, valid_o}, 32'd0);
        for (int k = 0; k < 30; k++) begin
            chk("fl.late", {31'd0, valid_o}, 32'd0);
            tick();
        end
        run_op(OP_ADD, RES_LOGIC, 32'd10, 32'd20, 5'd11, 1'b1, "fl.add");

        // Flush together with a valid instruction in IDLE.
        aluop_i  = OP_ADD;
        alusel_i = RES_LOGIC;
        reg1_i   = 32'd1;
        reg2_i   = 32'd1;
        wd_i     = 5'd2;
        wreg_i   = 1'b1;
        valid_i  = 1'b1;
        flush_i  = 1'b1;
        tick();
        valid_i  = 1'b0;
        flush_i  = 1'b0;
        chk("flv.valid", {31'd0, valid_o}, 32'd0);
        chk("flv.wdata", wdata_o, 32'd0);
        chk("flv.stall", {31'd0, stallreq_o}, 32'd0);

        // Reset at MUL iteration 20, together with flush and valid.
        start_mul(32'hdeadbeef, 32'h3);
        for (int k = 0; k < 20; k++) begin
            tick();
        end
        rst     = 1'b1;
        flush_i = 1'b1;
        valid_i = 1'b1;
        tick();
        rst     = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("rm.valid", {31'd0, valid_o}, 32'd0);
        chk("rm.wd", {27'd0, wd_o}, 32'd0);
        chk("rm.wreg", {31'd0, wreg_o}, 32'd0);
        chk("rm.wdata", wdata_o, 32'd0);
        chk("rm.stall", {31'd0, stallreq_o}, 32'd0);
        for (int k = 0; k < 40; k++) begin
            tick();
            chk("rm.late", {31'd0, valid_o}, 32'd0);
        end
        run_op(OP_XOR, RES_LOGIC, 32'hf0f0f0f0, 32'h0ff00ff0, 5'd12, 1'b1, "rm.xor");

        for (int n = 0; n < 60; n++) begin
            logic [7:0] op;
            logic [2:0] sel;
            op  = ops[$urandom_range(0, 8)];
            sel = ($urandom_range(0, 7) == 0) ? RES_NOP : RES_LOGIC;
            run_op(op, sel, $urandom, $urandom, 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
